// File: rtl/store_addr_unit_pkg.sv
// Shared types, size encodings and the ROB age compare used by store_addr_unit
// and by the other units that have to honour a pipeline flush.
package store_addr_unit_pkg;

   localparam int XLEN         = 64;
   localparam int PREG_W       = 7;
   localparam int ROB_SIZE_LOG = 5;
   localparam int SQ_SIZE_LOG  = 4;

   // One-hot access size encodings.
   localparam logic [3:0] LS_B = 4'b0001;
   localparam logic [3:0] LS_H = 4'b0010;
   localparam logic [3:0] LS_W = 4'b0100;
   localparam logic [3:0] LS_D = 4'b1000;

   // Operands captured at issue, held in the first stage.
   typedef struct packed {
      logic [XLEN-1:0]       rs1;
      logic [XLEN-1:0]       rs2;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       pc;
      logic [3:0]            size;
      logic [ROB_SIZE_LOG:0] robid;
      logic [SQ_SIZE_LOG:0]  sqid;
   } st_s1_t;

   // True when robid_a is strictly younger than robid_b. The MSB is the wrap bit:
   // with equal wrap bits the larger index is younger, otherwise the smaller one.
   function automatic logic is_younger(input logic [ROB_SIZE_LOG:0] robid_a,
                                       input logic [ROB_SIZE_LOG:0] robid_b);
      if (robid_a[ROB_SIZE_LOG] == robid_b[ROB_SIZE_LOG])
         return robid_a[ROB_SIZE_LOG-1:0] > robid_b[ROB_SIZE_LOG-1:0];
      else
         return robid_a[ROB_SIZE_LOG-1:0] < robid_b[ROB_SIZE_LOG-1:0];
   endfunction

endpackage

// File: rtl/store_addr_unit_lane_gen.sv
// Byte-lane generation for a store: byte enables, lane-shifted data and the
// natural-alignment check. Purely combinational.
module st_lane_gen
   import store_addr_unit_pkg::*;
(
   input  logic [2:0]      addr_lo,
   input  logic [3:0]      size,
   input  logic [XLEN-1:0] rs2,
   output logic [7:0]      mask,
   output logic [XLEN-1:0] data,
   output logic            misalign
);

   logic [7:0] base_mask;
   logic [2:0] align_bits;

   // Decode size to a base mask and the address bits that must be zero;
   // an invalid (non-one-hot) size yields no byte enables and a fault.
   always_comb begin
      base_mask  = 8'h00;
      align_bits = 3'b000;
      misalign   = 1'b1;
      unique case (size)
         LS_B: begin base_mask = 8'h01; align_bits = 3'b000; misalign = 1'b0; end
         LS_H: begin base_mask = 8'h03; align_bits = 3'b001; misalign = 1'b0; end
         LS_W: begin base_mask = 8'h0F; align_bits = 3'b011; misalign = 1'b0; end
         LS_D: begin base_mask = 8'hFF; align_bits = 3'b111; misalign = 1'b0; end
         default: ;
      endcase
      if ((addr_lo & align_bits) != 3'b000)
         misalign = 1'b1;
      mask = base_mask << addr_lo;
      data = rs2 << {addr_lo, 3'b000};
   end

endmodule

// File: rtl/store_addr_unit.sv
// Store address unit: accepts stores from the issue queue, reads operands from
// the regfile, forms address/mask/lane data and writes the store-queue entry,
// reporting completion to the ROB. Two stages (operands, outputs), both flushable.
module store_addr_unit
   import store_addr_unit_pkg::*;
#(
   parameter int VADDR_W = 64
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    issue_st0_valid,
   output logic                    issue_st0_ready,
   input  logic [PREG_W-1:0]       issue_st0_prs1,
   input  logic [PREG_W-1:0]       issue_st0_prs2,
   input  logic [VADDR_W-1:0]      issue_st0_imm,
   input  logic [VADDR_W-1:0]      issue_st0_pc,
   input  logic [3:0]              issue_st0_ls_size,
   input  logic [ROB_SIZE_LOG:0]   issue_st0_robid,
   input  logic [SQ_SIZE_LOG:0]    issue_st0_sqid,
   output logic [PREG_W-1:0]       rf_rs1_idx,
   output logic [PREG_W-1:0]       rf_rs2_idx,
   input  logic [63:0]             rf_rs1_data,
   input  logic [63:0]             rf_rs2_data,
   output logic                    sq_wr_valid,
   input  logic                    sq_wr_ready,
   output logic [SQ_SIZE_LOG:0]    sq_wr_sqid,
   output logic [VADDR_W-1:0]      sq_wr_addr,
   output logic [63:0]             sq_wr_data,
   output logic [7:0]              sq_wr_mask,
   output logic                    sq_wr_misalign,
   output logic                    cmpl_valid,
   output logic [ROB_SIZE_LOG:0]   cmpl_robid,
   output logic                    cmpl_exc,
   output logic [VADDR_W-1:0]      cmpl_pc,
   input  logic                    flush_valid,
   input  logic [ROB_SIZE_LOG:0]   flush_robid
);

   st_s1_t                s1_q, s1_d;
   logic                  s1_valid_q, s1_valid_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [SQ_SIZE_LOG:0]  s2_sqid_q, s2_sqid_d;
   logic [VADDR_W-1:0]    s2_addr_q, s2_addr_d;
   logic [63:0]           s2_data_q, s2_data_d;
   logic [7:0]            s2_mask_q, s2_mask_d;
   logic                  s2_misalign_q, s2_misalign_d;
   logic [ROB_SIZE_LOG:0] s2_robid_q, s2_robid_d;
   logic [VADDR_W-1:0]    s2_pc_q, s2_pc_d;

   logic            adv1, adv2, accept;
   logic            kill_in, kill_s1, kill_s2;
   logic [XLEN-1:0] s1_addr;
   logic [7:0]      lane_mask;
   logic [XLEN-1:0] lane_data;
   logic            lane_misalign;

   assign rf_rs1_idx = issue_st0_prs1;
   assign rf_rs2_idx = issue_st0_prs2;

   assign adv2            = !s2_valid_q || sq_wr_ready;
   assign adv1            = !s1_valid_q || adv2;
   assign issue_st0_ready = adv1;
   assign accept          = issue_st0_valid && adv1;

   assign kill_in = flush_valid && is_younger(issue_st0_robid, flush_robid);
   assign kill_s1 = flush_valid && is_younger(s1_q.robid, flush_robid);
   assign kill_s2 = flush_valid && is_younger(s2_robid_q, flush_robid);

   assign s1_addr = s1_q.rs1 + s1_q.imm;

   st_lane_gen u_lane_gen (
      .addr_lo  (s1_addr[2:0]),
      .size     (s1_q.size),
      .rs2      (s1_q.rs2),
      .mask     (lane_mask),
      .data     (lane_data),
      .misalign (lane_misalign)
   );

   // Next state for both stages: advance on the handshake, hold otherwise,
   // and drop any entry the flush marks as younger.
   always_comb begin
      s1_d          = s1_q;
      s1_valid_d    = s1_valid_q;
      s2_valid_d    = s2_valid_q;
      s2_sqid_d     = s2_sqid_q;
      s2_addr_d     = s2_addr_q;
      s2_data_d     = s2_data_q;
      s2_mask_d     = s2_mask_q;
      s2_misalign_d = s2_misalign_q;
      s2_robid_d    = s2_robid_q;
      s2_pc_d       = s2_pc_q;

      if (adv1) begin
         s1_valid_d = accept && !kill_in;
         if (accept) begin
            s1_d.rs1   = rf_rs1_data;
            s1_d.rs2   = rf_rs2_data;
            s1_d.imm   = XLEN'(issue_st0_imm);
            s1_d.pc    = XLEN'(issue_st0_pc);
            s1_d.size  = issue_st0_ls_size;
            s1_d.robid = issue_st0_robid;
            s1_d.sqid  = issue_st0_sqid;
         end
      end else begin
         s1_valid_d = s1_valid_q && !kill_s1;
      end

      if (adv2) begin
         s2_valid_d = s1_valid_q && !kill_s1;
         if (s1_valid_q) begin
            s2_sqid_d     = s1_q.sqid;
            s2_addr_d     = s1_addr[VADDR_W-1:0];
            s2_data_d     = lane_data;
            s2_mask_d     = lane_mask;
            s2_misalign_d = lane_misalign;
            s2_robid_d    = s1_q.robid;
            s2_pc_d       = s1_q.pc[VADDR_W-1:0];
         end
      end else begin
         s2_valid_d = s2_valid_q && !kill_s2;
      end
   end

   // Stage registers; reset clears both stages immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q          <= '0;
         s1_valid_q    <= 1'b0;
         s2_valid_q    <= 1'b0;
         s2_sqid_q     <= '0;
         s2_addr_q     <= '0;
         s2_data_q     <= '0;
         s2_mask_q     <= '0;
         s2_misalign_q <= 1'b0;
         s2_robid_q    <= '0;
         s2_pc_q       <= '0;
      end else begin
         s1_q          <= s1_d;
         s1_valid_q    <= s1_valid_d;
         s2_valid_q    <= s2_valid_d;
         s2_sqid_q     <= s2_sqid_d;
         s2_addr_q     <= s2_addr_d;
         s2_data_q     <= s2_data_d;
         s2_mask_q     <= s2_mask_d;
         s2_misalign_q <= s2_misalign_d;
         s2_robid_q    <= s2_robid_d;
         s2_pc_q       <= s2_pc_d;
      end
   end

   assign sq_wr_valid    = s2_valid_q;
   assign sq_wr_sqid     = s2_sqid_q;
   assign sq_wr_addr     = s2_addr_q;
   assign sq_wr_data     = s2_data_q;
   assign sq_wr_mask     = s2_mask_q;
   assign sq_wr_misalign = s2_misalign_q;
   assign cmpl_valid     = s2_valid_q;
   assign cmpl_robid     = s2_robid_q;
   assign cmpl_exc       = s2_misalign_q;
   assign cmpl_pc        = s2_pc_q;

endmodule

// File: tb/tb_store_addr_unit.sv
// Directed bench for store_addr_unit: lane generation, backpressure, flush
// ordering across the ROB wrap bit, and asynchronous reset.
module tb_store_addr_unit;
   import store_addr_unit_pkg::*;

   localparam int VW = 64;

   logic                  clock = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  issue_st0_valid;
   logic                  issue_st0_ready;
   logic [PREG_W-1:0]     issue_st0_prs1, issue_st0_prs2;
   logic [VW-1:0]         issue_st0_imm, issue_st0_pc;
   logic [3:0]            issue_st0_ls_size;
   logic [ROB_SIZE_LOG:0] issue_st0_robid;
   logic [SQ_SIZE_LOG:0]  issue_st0_sqid;
   logic [PREG_W-1:0]     rf_rs1_idx, rf_rs2_idx;
   logic [63:0]           rf_rs1_data, rf_rs2_data;
   logic                  sq_wr_valid, sq_wr_ready;
   logic [SQ_SIZE_LOG:0]  sq_wr_sqid;
   logic [VW-1:0]         sq_wr_addr;
   logic [63:0]           sq_wr_data;
   logic [7:0]            sq_wr_mask;
   logic                  sq_wr_misalign;
   logic                  cmpl_valid;
   logic [ROB_SIZE_LOG:0] cmpl_robid;
   logic                  cmpl_exc;
   logic [VW-1:0]         cmpl_pc;
   logic                  flush_valid;
   logic [ROB_SIZE_LOG:0] flush_robid;

   logic [63:0] rf [0:127];

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   assign rf_rs1_data = rf[rf_rs1_idx];
   assign rf_rs2_data = rf[rf_rs2_idx];

   store_addr_unit #(.VADDR_W(VW)) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .issue_st0_valid   (issue_st0_valid),
      .issue_st0_ready   (issue_st0_ready),
      .issue_st0_prs1    (issue_st0_prs1),
      .issue_st0_prs2    (issue_st0_prs2),
      .issue_st0_imm     (issue_st0_imm),
      .issue_st0_pc      (issue_st0_pc),
      .issue_st0_ls_size (issue_st0_ls_size),
      .issue_st0_robid   (issue_st0_robid),
      .issue_st0_sqid    (issue_st0_sqid),
      .rf_rs1_idx        (rf_rs1_idx),
      .rf_rs2_idx        (rf_rs2_idx),
      .rf_rs1_data       (rf_rs1_data),
      .rf_rs2_data       (rf_rs2_data),
      .sq_wr_valid       (sq_wr_valid),
      .sq_wr_ready       (sq_wr_ready),
      .sq_wr_sqid        (sq_wr_sqid),
      .sq_wr_addr        (sq_wr_addr),
      .sq_wr_data        (sq_wr_data),
      .sq_wr_mask        (sq_wr_mask),
      .sq_wr_misalign    (sq_wr_misalign),
      .cmpl_valid        (cmpl_valid),
      .cmpl_robid        (cmpl_robid),
      .cmpl_exc          (cmpl_exc),
      .cmpl_pc           (cmpl_pc),
      .flush_valid       (flush_valid),
      .flush_robid       (flush_robid)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic drive(input logic [PREG_W-1:0] prs1, input logic [PREG_W-1:0] prs2,
                        input logic [63:0] imm, input logic [3:0] size,
                        input logic [ROB_SIZE_LOG:0] robid, input logic [SQ_SIZE_LOG:0] sqid);
      issue_st0_valid   = 1'b1;
      issue_st0_prs1    = prs1;
      issue_st0_prs2    = prs2;
      issue_st0_imm     = imm;
      issue_st0_pc      = 64'h4000 + 64'(sqid);
      issue_st0_ls_size = size;
      issue_st0_robid   = robid;
      issue_st0_sqid    = sqid;
   endtask

   task automatic idle();
      issue_st0_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rf[i] = 64'h0;
      rf[1] = 64'h1000;
      rf[2] = 64'h1122334455667788;
      rf[3] = 64'hAB;
      issue_st0_valid   = 1'b0;
      issue_st0_prs1    = '0;
      issue_st0_prs2    = '0;
      issue_st0_imm     = '0;
      issue_st0_pc      = '0;
      issue_st0_ls_size = LS_D;
      issue_st0_robid   = '0;
      issue_st0_sqid    = '0;
      sq_wr_ready       = 1'b1;
      flush_valid       = 1'b0;
      flush_robid       = '0;

      // Reset state
      step(); step();
      check("rst_sq_valid", 64'(sq_wr_valid), 64'd0);
      check("rst_cmpl_valid", 64'(cmpl_valid), 64'd0);
      check("rst_misalign", 64'(sq_wr_misalign), 64'd0);
      check("rst_exc", 64'(cmpl_exc), 64'd0);
      check("rst_addr", sq_wr_addr, 64'd0);
      check("rst_data", sq_wr_data, 64'd0);
      check("rst_mask", 64'(sq_wr_mask), 64'd0);
      check("rst_ready", 64'(issue_st0_ready), 64'd1);
      reset_n = 1'b1;
      step();

      // SD, aligned, 0x1000 + 8
      drive(7'd1, 7'd2, 64'd8, LS_D, 6'd1, 5'd2);
      step(); idle(); step();
      check("sd_valid", 64'(sq_wr_valid), 64'd1);
      check("sd_cmpl_valid", 64'(cmpl_valid), 64'd1);
      check("sd_addr", sq_wr_addr, 64'h1008);
      check("sd_mask", 64'(sq_wr_mask), 64'hFF);
      check("sd_data", sq_wr_data, 64'h1122334455667788);
      check("sd_misalign", 64'(sq_wr_misalign), 64'd0);
      check("sd_robid", 64'(cmpl_robid), 64'd1);
      check("sd_sqid", 64'(sq_wr_sqid), 64'd2);
      check("sd_pc", cmpl_pc, 64'h4002);
      step();
      check("sd_drained", 64'(sq_wr_valid), 64'd0);

      // SB at 0x1003
      drive(7'd1, 7'd3, 64'd3, LS_B, 6'd2, 5'd3);
      step(); idle(); step();
      check("sb_addr", sq_wr_addr, 64'h1003);
      check("sb_mask", 64'(sq_wr_mask), 64'h08);
      check("sb_data", sq_wr_data, 64'hAB000000);
      check("sb_misalign", 64'(sq_wr_misalign), 64'd0);

      // SW at 0x1002: misaligned but still written
      drive(7'd1, 7'd3, 64'd2, LS_W, 6'd3, 5'd4);
      step(); idle(); step();
      check("sw_valid", 64'(sq_wr_valid), 64'd1);
      check("sw_mask", 64'(sq_wr_mask), 64'h3C);
      check("sw_data", sq_wr_data, 64'hAB0000);
      check("sw_misalign", 64'(sq_wr_misalign), 64'd1);
      check("sw_exc", 64'(cmpl_exc), 64'd1);

      // Non-one-hot size
      drive(7'd1, 7'd2, 64'd0, 4'b0011, 6'd4, 5'd5);
      step(); idle(); step();
      check("bad_mask", 64'(sq_wr_mask), 64'h00);
      check("bad_misalign", 64'(sq_wr_misalign), 64'd1);
      step();
      check("bad_drained", 64'(sq_wr_valid), 64'd0);

      // Backpressure: back-to-back stores, store queue stalled 3 cycles
      sq_wr_ready = 1'b0;
      drive(7'd1, 7'd2, 64'h00, LS_D, 6'd6, 5'd10);
      step();
      drive(7'd1, 7'd2, 64'h10, LS_D, 6'd7, 5'd11);
      step();
      check("bp_ready_low", 64'(issue_st0_ready), 64'd0);
      check("bp_valid", 64'(sq_wr_valid), 64'd1);
      check("bp_sqid", 64'(sq_wr_sqid), 64'd10);
      drive(7'd1, 7'd2, 64'h20, LS_D, 6'd8, 5'd12);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_ready", 64'(issue_st0_ready), 64'd0);
         check("bp_hold_sqid", 64'(sq_wr_sqid), 64'd10);
         check("bp_hold_addr", sq_wr_addr, 64'h1000);
      end
      sq_wr_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(issue_st0_ready), 64'd1);
      step();
      check("bp_out_b", 64'(sq_wr_sqid), 64'd11);
      check("bp_out_b_addr", sq_wr_addr, 64'h1010);
      drive(7'd1, 7'd2, 64'h30, LS_D, 6'd9, 5'd13);
      step(); idle();
      check("bp_out_c", 64'(sq_wr_sqid), 64'd12);
      check("bp_out_c_addr", sq_wr_addr, 64'h1020);
      step();
      check("bp_out_d", 64'(sq_wr_sqid), 64'd13);
      check("bp_out_d_valid", 64'(sq_wr_valid), 64'd1);
      step();
      check("bp_empty", 64'(sq_wr_valid), 64'd0);

      // Flush across wrap: flush {1,2}, S1 {1,5} killed, S2 {0,30} survives
      sq_wr_ready = 1'b0;
      drive(7'd1, 7'd2, 64'd0, LS_D, {1'b0, 5'd30}, 5'd1);
      step();
      drive(7'd1, 7'd2, 64'd0, LS_D, {1'b1, 5'd5}, 5'd2);
      step(); idle();
      flush_valid = 1'b1;
      flush_robid = {1'b1, 5'd2};
      step();
      flush_valid = 1'b0;
      check("wrap_s2_valid", 64'(sq_wr_valid), 64'd1);
      check("wrap_s2_robid", 64'(cmpl_robid), 64'd30);
      sq_wr_ready = 1'b1;
      step();
      check("wrap_s1_killed", 64'(sq_wr_valid), 64'd0);

      // Flush kills a stalled S2 entry
      sq_wr_ready = 1'b0;
      drive(7'd1, 7'd2, 64'd0, LS_D, {1'b1, 5'd6}, 5'd3);
      step(); idle(); step();
      check("s2kill_pre", 64'(sq_wr_valid), 64'd1);
      flush_valid = 1'b1;
      flush_robid = {1'b1, 5'd2};
      step();
      flush_valid = 1'b0;
      check("s2kill_dropped", 64'(sq_wr_valid), 64'd0);
      sq_wr_ready = 1'b1;

      // Flush in the same cycle as accept: {1,3} killed, {1,2} survives
      drive(7'd1, 7'd2, 64'd0, LS_D, {1'b1, 5'd3}, 5'd4);
      flush_valid = 1'b1;
      flush_robid = {1'b1, 5'd2};
      step(); idle();
      flush_valid = 1'b0;
      step();
      check("inkill_t2", 64'(sq_wr_valid), 64'd0);
      step();
      check("inkill_t3", 64'(sq_wr_valid), 64'd0);
      drive(7'd1, 7'd2, 64'd0, LS_D, {1'b1, 5'd2}, 5'd5);
      flush_valid = 1'b1;
      flush_robid = {1'b1, 5'd2};
      step(); idle();
      flush_valid = 1'b0;
      step();
      check("insurv_valid", 64'(sq_wr_valid), 64'd1);
      check("insurv_robid", 64'(cmpl_robid), 64'(6'b100010));
      check("insurv_sqid", 64'(sq_wr_sqid), 64'd5);
      step();

      // Asynchronous reset with both stages full
      sq_wr_ready = 1'b0;
      drive(7'd1, 7'd2, 64'd0, LS_D, 6'd10, 5'd6);
      step();
      drive(7'd1, 7'd2, 64'd0, LS_D, 6'd11, 5'd7);
      step(); idle();
      check("ar_pre_valid", 64'(sq_wr_valid), 64'd1);
      check("ar_pre_ready", 64'(issue_st0_ready), 64'd0);
      #2 reset_n = 1'b0;
      #1;
      check("ar_sq_valid", 64'(sq_wr_valid), 64'd0);
      check("ar_cmpl_valid", 64'(cmpl_valid), 64'd0);
      check("ar_addr", sq_wr_addr, 64'd0);
      check("ar_ready", 64'(issue_st0_ready), 64'd1);
      step();
      reset_n = 1'b1;
      step();
      check("ar_post_valid", 64'(sq_wr_valid), 64'd0);
      check("ar_post_ready", 64'(issue_st0_ready), 64'd1);
      sq_wr_ready = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
